// File: rtl/scope_trigger_ctrl.sv
// Scope capture sequencer: circular sample buffer, level/edge trigger,
// post-trigger stop, time-ordered readout. Optional: SCOPE_TRIG_TIMEOUT_EN.
module scope_trigger_ctrl #(
    parameter int pDataBits    = 8,
    parameter int pDepthBits   = 10,
    parameter int pTimeoutBits = 20
) (
    input  logic                    iClk,
    input  logic                    inRst,
    input  logic [pDataBits-1:0]    iData,
    input  logic                    iData_Valid,
    input  logic                    iArm,
    input  logic                    iForce,
    input  logic [pDataBits-1:0]    iTrigLevel,
    input  logic                    iTrigRising,
    input  logic [pDepthBits-1:0]   iPreTrig,
    input  logic [pTimeoutBits-1:0] iTimeout,
    input  logic                    iRdReq,
    output logic [pDataBits-1:0]    oRdData,
    output logic                    oRdValid,
    output logic                    oRdLast,
    output logic                    oDone,
    output logic [2:0]              oState
);

    typedef enum logic [2:0] {
        sIdle    = 3'd0,
        sPreTrig = 3'd1,
        sWait    = 3'd2,
        sPost    = 3'd3,
        sDone    = 3'd4
    } state_t;

    localparam int lDepth = 1 << pDepthBits;

    logic [pDataBits-1:0]  mem [lDepth];
    state_t                state;
    logic [pDepthBits-1:0] wptr;
    logic [pDepthBits-1:0] preLat;
    logic [pDepthBits-1:0] preCnt;
    logic [pDepthBits-1:0] postCnt;
    logic [pDepthBits-1:0] trigAddr;
    logic [pDepthBits-1:0] rcnt;
    logic [pDepthBits-1:0] rdAddr;
    logic [pDataBits-1:0]  levelLat;
    logic [pDataBits-1:0]  prevSample;
    logic [pDataBits-1:0]  rdData;
    logic                  risingLat;
    logic                  prevValid;
    logic                  forceFlag;
    logic                  rdValid;
    logic                  rdLast;
    logic                  done;
    logic                  capturing;
    logic                  wrEn;
    logic                  edgeHit;
    logic                  autoTrig;
    logic                  trigHit;
    logic                  armNow;

    // The POST cycle with nothing left to count must not write: that
    // slot holds the oldest sample of the frame.
    assign capturing = (state == sPreTrig) || (state == sWait) ||
                       ((state == sPost) && (postCnt != '0));
    assign wrEn      = capturing && iData_Valid;
    assign armNow    = iArm && ((state == sIdle) || (state == sDone));
    assign edgeHit   = prevValid && (risingLat ?
                       ((prevSample < levelLat) && (iData >= levelLat)) :
                       ((prevSample > levelLat) && (iData <= levelLat)));
    assign trigHit   = (state == sWait) && iData_Valid &&
                       (forceFlag || autoTrig || edgeHit);
    assign rdAddr    = trigAddr - preLat + rcnt;

`ifdef SCOPE_TRIG_TIMEOUT_EN
    logic [pTimeoutBits-1:0] toCnt;

    assign autoTrig = (iTimeout != '0) && (toCnt >= iTimeout);

    // Count valid samples spent waiting; saturate so it never wraps
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            toCnt <= '0;
        end else if (state != sWait) begin
            toCnt <= '0;
        end else if (iData_Valid && (toCnt != '1)) begin
            toCnt <= toCnt + 1'b1;
        end
    end
`else
    logic unusedTimeout;

    assign autoTrig      = 1'b0;
    assign unusedTimeout = ^iTimeout;
`endif

    // Sample buffer write port (BRAM, no reset)
    always_ff @(posedge iClk) begin
        if (wrEn) begin
            mem[wptr] <= iData;
        end
    end

    // Capture / readout sequencer with registered outputs
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            state      <= sIdle;
            wptr       <= '0;
            preLat     <= '0;
            preCnt     <= '0;
            postCnt    <= '0;
            trigAddr   <= '0;
            rcnt       <= '0;
            levelLat   <= '0;
            prevSample <= '0;
            risingLat  <= 1'b0;
            prevValid  <= 1'b0;
            forceFlag  <= 1'b0;
            rdData     <= '0;
            rdValid    <= 1'b0;
            rdLast     <= 1'b0;
            done       <= 1'b0;
        end else begin
            rdValid <= 1'b0;
            rdLast  <= 1'b0;
            if (wrEn) begin
                wptr       <= wptr + 1'b1;
                prevSample <= iData;
                prevValid  <= 1'b1;
            end
            if (armNow) begin
                preLat    <= iPreTrig;
                levelLat  <= iTrigLevel;
                risingLat <= iTrigRising;
                preCnt    <= '0;
                postCnt   <= '0;
                rcnt      <= '0;
                prevValid <= 1'b0;
                forceFlag <= 1'b0;
                done      <= 1'b0;
                state     <= sPreTrig;
            end else begin
                unique case (state)
                    sIdle: begin
                    end
                    sPreTrig: begin
                        if (preCnt == preLat) begin
                            state <= sWait;
                        end else if (iData_Valid) begin
                            preCnt <= preCnt + 1'b1;
                            if (preCnt + 1'b1 == preLat) begin
                                state <= sWait;
                            end
                        end
                    end
                    sWait: begin
                        if (trigHit) begin
                            trigAddr  <= wptr;
                            postCnt   <= ~preLat;
                            forceFlag <= 1'b0;
                            state     <= sPost;
                        end else if (iForce) begin
                            forceFlag <= 1'b1;
                        end
                    end
                    sPost: begin
                        if (postCnt == '0) begin
                            done  <= 1'b1;
                            state <= sDone;
                        end else if (iData_Valid) begin
                            postCnt <= postCnt - 1'b1;
                            if (postCnt == pDepthBits'(1)) begin
                                done  <= 1'b1;
                                state <= sDone;
                            end
                        end
                    end
                    sDone: begin
                        if (iRdReq) begin
                            rdData  <= mem[rdAddr];
                            rdValid <= 1'b1;
                            rcnt    <= rcnt + 1'b1;
                            if (rcnt == '1) begin
                                rdLast <= 1'b1;
                                done   <= 1'b0;
                                state  <= sIdle;
                            end
                        end
                    end
                    default: begin
                        state <= sIdle;
                    end
                endcase
            end
        end
    end

    assign oRdData  = rdData;
    assign oRdValid = rdValid;
    assign oRdLast  = rdLast;
    assign oDone    = done;
    assign oState   = state;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Directed bench for scope_trigger_ctrl at pDepthBits=4.
// Covers ramp/falling/force/pretrig/reset/pre-max and optional timeout.
module tb_scope_trigger_ctrl;

    logic        iClk = 1'b0;
    logic        inRst = 1'b0;
    logic [7:0]  iData = '0;
    logic        iData_Valid = 1'b0;
    logic        iArm = 1'b0;
    logic        iForce = 1'b0;
    logic [7:0]  iTrigLevel = '0;
    logic        iTrigRising = 1'b0;
    logic [3:0]  iPreTrig = '0;
    logic [19:0] iTimeout = '0;
    logic        iRdReq = 1'b0;
    logic [7:0]  oRdData;
    logic        oRdValid;
    logic        oRdLast;
    logic        oDone;
    logic [2:0]  oState;

    int checks = 0;
    int errors = 0;

    scope_trigger_ctrl #(
        .pDataBits(8),
        .pDepthBits(4),
        .pTimeoutBits(20)
    ) dut (
        .iClk(iClk),
        .inRst(inRst),
        .iData(iData),
        .iData_Valid(iData_Valid),
        .iArm(iArm),
        .iForce(iForce),
        .iTrigLevel(iTrigLevel),
        .iTrigRising(iTrigRising),
        .iPreTrig(iPreTrig),
        .iTimeout(iTimeout),
        .iRdReq(iRdReq),
        .oRdData(oRdData),
        .oRdValid(oRdValid),
        .oRdLast(oRdLast),
        .oDone(oDone),
        .oState(oState)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic sendSample(input logic [7:0] d, input int gap);
        iData = d;
        iData_Valid = 1'b1;
        tick();
        iData_Valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic armCap(input logic [3:0] pre, input logic [7:0] lvl,
                          input logic rise);
        iPreTrig = pre;
        iTrigLevel = lvl;
        iTrigRising = rise;
        iArm = 1'b1;
        tick();
        iArm = 1'b0;
    endtask

    task automatic pulseReset();
        inRst = 1'b0;
        #2;
        inRst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iClk);
        #1;
        checks++;
        if (oState !== 3'd0) begin
            errors++; $display("FAIL rst_state got %0d want 0", oState);
        end
        checks++;
        if (oDone !== 1'b0) begin
            errors++; $display("FAIL rst_done got %b want 0", oDone);
        end
        checks++;
        if (oRdValid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got %b want 0", oRdValid);
        end
        checks++;
        if (oRdLast !== 1'b0) begin
            errors++; $display("FAIL rst_last got %b want 0", oRdLast);
        end
        checks++;
        if (oRdData !== 8'h00) begin
            errors++; $display("FAIL rst_data got %h want 00", oRdData);
        end
        inRst = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        logic [7:0] exp;
        iRdReq = 1'b1;
        tick();
        iRdReq = 1'b0;
        checks++;
        if (oRdValid !== 1'b0) begin
            errors++; $display("FAIL idle_rdreq valid got %b want 0", oRdValid);
        end
        armCap(4'd4, 8'h80, 1'b1);
        checks++;
        if (oState !== 3'd1) begin
            errors++; $display("FAIL ramp_arm state got %0d want 1", oState);
        end
        for (int n = 0; n < 20; n++) begin
            sendSample(8'(n * 16), 4);
            if (n == 3 || n == 7) begin
                checks++;
                if (oState !== 3'd2) begin
                    errors++;
                    $display("FAIL ramp_wait n=%0d state got %0d want 2", n, oState);
                end
            end
            if (n == 8) begin
                checks++;
                if (oState !== 3'd3) begin
                    errors++; $display("FAIL ramp_trig state got %0d want 3", oState);
                end
            end
        end
        checks++;
        if (oState !== 3'd4 || oDone !== 1'b1) begin
            errors++;
            $display("FAIL ramp_done state/done got %0d/%b want 4/1", oState, oDone);
        end
        for (int i = 0; i < 16; i++) begin
            exp = 8'h40 + 8'(i * 16);
            iRdReq = 1'b1;
            tick();
            iRdReq = 1'b0;
            checks++;
            if (oRdValid !== 1'b1 || oRdData !== exp) begin
                errors++;
                $display("FAIL ramp_read i=%0d got %b/%h want 1/%h", i, oRdValid, oRdData, exp);
            end
            checks++;
            if (oRdLast !== (i == 15)) begin
                errors++; $display("FAIL ramp_last i=%0d got %b", i, oRdLast);
            end
            if (i == 14) begin
                checks++;
                if (oDone !== 1'b1) begin
                    errors++; $display("FAIL ramp_done14 got %b want 1", oDone);
                end
            end
            tick();
        end
        checks++;
        if (oState !== 3'd0 || oDone !== 1'b0 || oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_end got %0d/%b/%b want 0/0/0", oState, oDone, oRdValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        armCap(4'd2, 8'h80, 1'b0);
        for (int n = 0; n < 21; n++) begin
            sendSample(8'hF0 - 8'(16 * n), 1);
            if (n == 6 || n == 7) begin
                checks++;
                if (oState !== ((n == 7) ? 3'd3 : 3'd2)) begin
                    errors++; $display("FAIL fall_state n=%0d got %0d", n, oState);
                end
            end
        end
        checks++;
        if (oState !== 3'd4) begin
            errors++; $display("FAIL fall_done got %0d want 4", oState);
        end
        iRdReq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 8'hA0 - 8'(16 * i);
            tick();
            checks++;
            if (oRdValid !== 1'b1 || oRdData !== exp || oRdLast !== (i == 15)) begin
                errors++;
                $display("FAIL b2b_read i=%0d got %b/%h/%b want 1/%h", i, oRdValid, oRdData, oRdLast, exp);
            end
        end
        iRdReq = 1'b0;
        checks++;
        if (oState !== 3'd0) begin
            errors++; $display("FAIL b2b_end state got %0d want 0", oState);
        end
        tick();
    endtask

    task automatic test_pretrig_ignore();
        logic [7:0] vals [12];
        logic [7:0] exp [16];
        vals = '{8'h00, 8'h10, 8'h50, 8'h50, 8'h20, 8'h20,
                 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h60};
        exp = '{8'h50, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
                8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        armCap(4'd8, 8'h40, 1'b1);
        for (int j = 0; j < 12; j++) begin
            sendSample(vals[j], 1);
            if (j == 2 || j == 6) begin
                checks++;
                if (oState !== 3'd1) begin
                    errors++; $display("FAIL pre_state j=%0d got %0d want 1", j, oState);
                end
            end
            if (j == 10) begin
                checks++;
                if (oState !== 3'd2) begin
                    errors++; $display("FAIL pre_wait got %0d want 2", oState);
                end
            end
            if (j == 11) begin
                checks++;
                if (oState !== 3'd3) begin
                    errors++; $display("FAIL pre_trig got %0d want 3", oState);
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            sendSample(8'h61 + 8'(k), 1);
        end
        checks++;
        if (oState !== 3'd4) begin
            errors++; $display("FAIL pre_done got %0d want 4", oState);
        end
        for (int i = 0; i < 16; i++) begin
            iRdReq = 1'b1;
            tick();
            iRdReq = 1'b0;
            checks++;
            if (oRdValid !== 1'b1 || oRdData !== exp[i]) begin
                errors++;
                $display("FAIL pre_read i=%0d got %b/%h want 1/%h", i, oRdValid, oRdData, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_force();
        armCap(4'd5, 8'h80, 1'b1);
        for (int n = 0; n < 8; n++) sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL force_wait got %0d want 2", oState);
        end
        iForce = 1'b1;
        tick();
        iForce = 1'b0;
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL force_pulse got %0d want 2", oState);
        end
        sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd3) begin
            errors++; $display("FAIL force_trig got %0d want 3", oState);
        end
        for (int n = 0; n < 9; n++) sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd3 || oDone !== 1'b0) begin
            errors++; $display("FAIL force_post9 got %0d/%b want 3/0", oState, oDone);
        end
        sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd4 || oDone !== 1'b1) begin
            errors++; $display("FAIL force_done got %0d/%b want 4/1", oState, oDone);
        end
        iPreTrig = 4'd5;
        iArm = 1'b1;
        iRdReq = 1'b1;
        tick();
        iArm = 1'b0;
        iRdReq = 1'b0;
        checks++;
        if (oState !== 3'd1 || oDone !== 1'b0 || oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL arm_prio got %0d/%b/%b want 1/0/0", oState, oDone, oRdValid);
        end
        sendSample(8'h20, 1);
        sendSample(8'h20, 1);
        iPreTrig = 4'd0;
        iArm = 1'b1;
        tick();
        iArm = 1'b0;
        tick();
        checks++;
        if (oState !== 3'd1) begin
            errors++; $display("FAIL arm_ignored got %0d want 1", oState);
        end
        for (int n = 0; n < 3; n++) sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL arm_ignored_wait got %0d want 2", oState);
        end
    endtask

    task automatic test_reset_mid();
        iForce = 1'b1;
        tick();
        iForce = 1'b0;
        for (int n = 0; n < 4; n++) sendSample(8'h30, 1);
        checks++;
        if (oState !== 3'd3) begin
            errors++; $display("FAIL mid_post got %0d want 3", oState);
        end
        inRst = 1'b0;
        #1;
        checks++;
        if (oState !== 3'd0 || oDone !== 1'b0 || oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got %0d/%b/%b want 0/0/0", oState, oDone, oRdValid);
        end
        #2;
        inRst = 1'b1;
        tick();
        armCap(4'd0, 8'h80, 1'b1);
        checks++;
        if (oState !== 3'd1) begin
            errors++; $display("FAIL pre0_arm got %0d want 1", oState);
        end
        tick();
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL pre0_wait got %0d want 2", oState);
        end
        pulseReset();
    endtask

    task automatic test_pre_max();
        logic [7:0] exp;
        armCap(4'd15, 8'h80, 1'b1);
        for (int n = 0; n < 24; n++) begin
            sendSample(8'(n * 16), 1);
            if (n == 14 || n == 23) begin
                checks++;
                if (oState !== 3'd2) begin
                    errors++; $display("FAIL max_wait n=%0d got %0d want 2", n, oState);
                end
            end
        end
        sendSample(8'h80, 0);
        checks++;
        if (oState !== 3'd3) begin
            errors++; $display("FAIL max_trig got %0d want 3", oState);
        end
        sendSample(8'h55, 1);
        checks++;
        if (oState !== 3'd4 || oDone !== 1'b1) begin
            errors++; $display("FAIL max_done got %0d/%b want 4/1", oState, oDone);
        end
        for (int i = 0; i < 16; i++) begin
            exp = 8'h90 + 8'(i * 16);
            iRdReq = 1'b1;
            tick();
            iRdReq = 1'b0;
            checks++;
            if (oRdValid !== 1'b1 || oRdData !== exp || oRdLast !== (i == 15)) begin
                errors++;
                $display("FAIL max_read i=%0d got %b/%h/%b want 1/%h", i, oRdValid, oRdData, oRdLast, exp);
            end
            tick();
        end
    endtask

`ifdef SCOPE_TRIG_TIMEOUT_EN
    task automatic test_timeout();
        iTimeout = 20'd6;
        armCap(4'd2, 8'h80, 1'b1);
        for (int n = 0; n < 8; n++) sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL to_wait got %0d want 2", oState);
        end
        sendSample(8'h20, 1);
        checks++;
        if (oState !== 3'd3) begin
            errors++; $display("FAIL to_trig got %0d want 3", oState);
        end
        pulseReset();
        iTimeout = 20'd0;
        armCap(4'd2, 8'h80, 1'b1);
        for (int n = 0; n < 102; n++) sendSample(8'h20, 0);
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL to_off got %0d want 2", oState);
        end
        pulseReset();
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_pretrig_ignore();
        test_force();
        test_reset_mid();
        test_pre_max();
`ifdef SCOPE_TRIG_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
